sequence_generator_serial: RTL and testbench

//   Serial pattern transmitter: the producer side of the serial sequence detectors.

---
 rtl/sequence_generator_serial.sv | 140 ++++++++++++++
 tb/tb_sequence_generator_serial.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator_serial.sv
// Serial pattern transmitter: latches a WIDTH-bit pattern on start and shifts it out
// MSB-first, repeat_cnt times, with optional idle gaps between repeats.
module sequence_generator_serial #(
  parameter int WIDTH      = 4,
  parameter int REP_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pat, pat_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             out_n, valid_n, busy_n, done_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pat     <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pat     <= pat_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      rep_cnt <= rep_cnt_n;
      gap_cnt <= gap_cnt_n;
      out     <= out_n;
      valid   <= valid_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Next-cycle values of every output are computed here so the outputs themselves are flops;
  // bit_cnt counts bits already presented on out in the current pattern.
  always_comb begin
    state_n   = state;
    pat_n     = pat;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    rep_cnt_n = rep_cnt;
    gap_cnt_n = gap_cnt;
    out_n     = out;
    valid_n   = valid;
    busy_n    = busy;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        out_n   = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        if (start) begin
          pat_n     = pattern_in;
          rep_cnt_n = repeat_cnt;
          if (repeat_cnt != '0) begin
            state_n   = SEND;
            busy_n    = 1'b1;
            valid_n   = 1'b1;
            out_n     = pattern_in[WIDTH-1];
            shift_n   = {pattern_in[WIDTH-2:0], 1'b0};
            bit_cnt_n = BIT_ONE;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SEND: begin
        if (bit_cnt != BIT_LAST) begin
          out_n     = shift[WIDTH-1];
          shift_n   = {shift[WIDTH-2:0], 1'b0};
          bit_cnt_n = bit_cnt + BIT_ONE;
        end else if (rep_cnt != REP_ONE) begin
          rep_cnt_n = rep_cnt - REP_ONE;
          if (GAP_CYCLES == 0) begin
            out_n     = pat[WIDTH-1];
            shift_n   = {pat[WIDTH-2:0], 1'b0};
            bit_cnt_n = BIT_ONE;
          end else begin
            state_n   = GAP;
            valid_n   = 1'b0;
            out_n     = 1'b0;
            gap_cnt_n = GAP_ONE;
            bit_cnt_n = '0;
          end
        end else begin
          state_n   = IDLE;
          out_n     = 1'b0;
          valid_n   = 1'b0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          rep_cnt_n = '0;
          bit_cnt_n = '0;
        end
      end
      GAP: begin
        if (gap_cnt != GAP_LAST) begin
          gap_cnt_n = gap_cnt + GAP_ONE;
        end else begin
          state_n   = SEND;
          gap_cnt_n = '0;
          valid_n   = 1'b1;
          out_n     = pat[WIDTH-1];
          shift_n   = {pat[WIDTH-2:0], 1'b0};
          bit_cnt_n = BIT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sequence_generator_serial.sv
// Scoreboard bench for sequence_generator_serial: a contiguous (gap 0) and a gapped (gap 2)
// instance share stimulus; expected bits/done pulses are queued with their cycle numbers.
module tb_sequence_generator_serial;

  localparam int W = 4;
  localparam int GAPS [2] = '{0, 2};

  typedef struct {
    int   cyc;
    logic b;
  } item_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] pattern_in;
  logic [3:0] repeat_cnt;
  logic       o [2];
  logic       v [2];
  logic       b [2];
  logic       d [2];

  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  item_t bq [2][$];
  int    dq [2][$];
  int    idle_from [2];
  int    busy_lo [2];
  int    busy_hi [2];
  int    det_cnt = 0;
  logic [2:0] hist = '0;

  sequence_generator_serial #(.WIDTH(4), .REP_W(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst), .start(start), .pattern_in(pattern_in), .repeat_cnt(repeat_cnt),
    .out(o[0]), .valid(v[0]), .busy(b[0]), .done(d[0]));

  sequence_generator_serial #(.WIDTH(4), .REP_W(4), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .reset(rst), .start(start), .pattern_in(pattern_in), .repeat_cnt(repeat_cnt),
    .out(o[1]), .valid(v[1]), .busy(b[1]), .done(d[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", nm, k, cyc, act, exp);
    end
  endtask

  // Reference model: a request either lands on an idle generator (schedule all of its
  // bits and the done pulse) or on a busy one (dropped).
  task automatic model(input logic [3:0] pat, input int r);
    int e;
    item_t it;
    e = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (cyc >= idle_from[k]) begin
        if (r == 0) begin
          dq[k].push_back(e);
          idle_from[k] = e;
        end else begin
          for (int rr = 0; rr < r; rr++)
            for (int i = 0; i < W; i++) begin
              it.cyc = e + rr * (W + GAPS[k]) + i;
              it.b   = pat[W-1-i];
              bq[k].push_back(it);
            end
          idle_from[k] = e + r * W + (r - 1) * GAPS[k];
          busy_lo[k]   = e;
          busy_hi[k]   = idle_from[k] - 1;
          dq[k].push_back(idle_from[k]);
        end
      end
    end
  endtask

  task automatic send(input logic [3:0] pat, input int r);
    pattern_in = pat;
    repeat_cnt = 4'(r);
    start      = 1'b1;
    model(pat, r);
    @(negedge clk);
    start      = 1'b0;
    pattern_in = 4'($urandom);
    repeat_cnt = 4'($urandom);
  endtask

  task automatic wait_idle();
    int tgt;
    tgt = (idle_from[0] > idle_from[1]) ? idle_from[0] : idle_from[1];
    while (cyc <= tgt) @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_out"}, k, int'(o[k]), 0);
      chk({nm, "_valid"}, k, int'(v[k]), 0);
      chk({nm, "_busy"}, k, int'(b[k]), 0);
      chk({nm, "_done"}, k, int'(d[k]), 0);
    end
  endtask

  task automatic flush_model();
    for (int k = 0; k < 2; k++) begin
      bq[k].delete();
      dq[k].delete();
      idle_from[k] = 0;
      busy_lo[k]   = 1;
      busy_hi[k]   = 0;
    end
  endtask

  always @(negedge clk) begin
    item_t it;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        if (v[k]) begin
          if (bq[k].size() == 0) chk("valid_unexpected", k, 1, 0);
          else begin
            it = bq[k].pop_front();
            chk("bit_cycle", k, cyc, it.cyc);
            chk("bit_value", k, int'(o[k]), int'(it.b));
          end
        end else begin
          chk("out_when_invalid", k, int'(o[k]), 0);
        end
        chk("busy", k, int'(b[k]), int'(cyc >= busy_lo[k] && cyc <= busy_hi[k]));
        if (d[k]) begin
          if (dq[k].size() == 0) chk("done_unexpected", k, 1, 0);
          else chk("done_cycle", k, cyc, dq[k].pop_front());
        end
      end
      if (v[0]) begin
        if ({hist, o[0]} == 4'b1101) det_cnt++;
        hist = {hist[1:0], o[0]};
      end
    end
  end

  initial begin
    int det_before;
    rst = 1'b0;
    start = 1'b0;
    pattern_in = '0;
    repeat_cnt = '0;
    flush_model();
    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);

    send(4'b1101, 1);
    wait_idle();

    det_before = det_cnt;
    send(4'b1101, 3);
    wait_idle();
    chk("detector_hits", 0, det_cnt - det_before, 3);

    send(4'b1011, 0);
    send(4'b1101, 1);
    @(negedge clk);
    send(4'b0110, 2);
    wait_idle();

    send(4'b1001, 15);
    wait_idle();

    send(4'b1101, 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("reset_abort");
    flush_model();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    send(4'b1010, 1);
    wait_idle();

    repeat (300) begin
      if ($urandom_range(0, 3) == 0) send(4'($urandom), int'($urandom_range(0, 3)));
      else @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("bits_missing", k, bq[k].size(), 0);
      chk("done_missing", k, dq[k].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
